tdm_mux: RTL
============

TDM_MUX -- requirements
Module: tdm_mux

Interface
REQ-001 Parameter HOLD, default 1, meaning cycles each slot is driven (legal 1..16).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to transmit one frame of din.
REQ-005 din  input  8  parallel frame; din[i] is the slot-i bit.
REQ-006 ack  output  1  one-cycle pulse, start accepted and din captured.
REQ-007 mout  output  1  serialized slot bit, the mirror of a demultiplexer input "a".
REQ-008 sel  output  3  current slot index, driven to the receiving demultiplexer.
REQ-009 mvalid  output  1  high while mout/sel carry a valid slot.
REQ-010 frame_end  output  1  one-cycle pulse during the final cycle of slot 7.
REQ-011 ovr  output  1  one-cycle pulse, start asserted while busy and not accepted.

Function
REQ-012 The FSM SHALL have exactly the states IDLE and SEND.
REQ-013 In IDLE with start=1, the block SHALL capture din into an 8-bit shadow register, pulse ack, and enter SEND on the next edge with sel=0.
REQ-014 In SEND, the block SHALL drive mout=shadow[sel], mvalid=1, and hold each sel value for exactly HOLD cycles.
REQ-015 sel SHALL advance 0,1,...,7 in strict order with no skipped or repeated slot.
REQ-016 Frame latency SHALL be: start accepted at cycle N, slot 0 visible at N+1, and the last slot-7 cycle at N+8*HOLD.
REQ-017 frame_end SHALL pulse during the last HOLD cycle of slot 7.
REQ-018 If start=1 in the frame_end cycle, the block SHALL recapture din, pulse ack, and present slot 0 of the new frame on the next cycle with no gap (back-to-back).
REQ-019 If start=0 in the frame_end cycle, the block SHALL return to IDLE, with sel=0, mout=0 and mvalid=0.
REQ-020 If start=1 in SEND in any cycle other than the frame_end cycle, the block SHALL ignore it, pulse ovr, and leave the shadow register unchanged.
REQ-021 Changes on din during SEND SHALL NOT affect mout.
REQ-022 All outputs SHALL be registered; there SHALL be no combinational path from inputs to outputs.
REQ-023 The slot-hold counter SHALL be 4 bits, count 0..HOLD-1, and wrap to 0 on each slot advance.
REQ-024 With HOLD=1, the block SHALL advance sel every cycle and SHALL still pulse frame_end exactly once per frame.

Reset
REQ-025 When rst_n=0, the block SHALL immediately force: state=IDLE, shadow=0, sel=0, mout=0, mvalid=0, ack=0, frame_end=0, ovr=0, hold counter=0.
REQ-026 Reset mid-frame SHALL abort the frame with no frame_end pulse.
REQ-027 After release, the first start SHALL behave per REQ-013.

Structure
REQ-028 Shared package tdm_pkg SHALL hold the state enum (IDLE, SEND), the constants SLOTS=8 and SEL_W=3, and HOLD_W=4.
REQ-029 The slot-hold counter SHALL be a sub-module slot_timer with inputs clk, rst_n, run, and outputs cnt and slot_done.
REQ-030 Demultiplexer receivers SHALL reuse tdm_pkg.

Verification
REQ-031 HOLD=1, din=8'b1010_0110, single start pulse -> ack at N; sel=0..7 on N+1..N+8; mout=0,1,1,0,0,1,0,1; frame_end at N+8; IDLE at N+9.
REQ-032 HOLD=3, din=8'hFF -> each sel value held 3 cycles; mout=1 throughout; frame_end only in cycle N+24.
REQ-033 start held high continuously, din=8'h0F then 8'hF0 -> frames back-to-back with no mvalid gap; second frame mout=0,0,0,0,1,1,1,1.
REQ-034 start pulsed at slot 3 of a frame -> ovr pulse, no ack, current frame unchanged.
REQ-035 rst_n low at slot 5 -> all outputs 0 at once; no frame_end; next start gives a normal frame.
REQ-036 din toggled every cycle during SEND -> mout matches the captured value only; a receiving demultiplexer chained to sel/mout reproduces the captured din.

Source files
------------

// File: rtl/tdm_mux_pkg.sv
// rtl/tdm_mux_pkg.sv - shared TDM types and constants
// Purpose: state enum and slot geometry shared by the multiplexer and
//          any demultiplexer receivers.
// Ports:   none (package).
package tdm_pkg;
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tdm_state_e;

  localparam int SLOTS  = 8;
  localparam int SEL_W  = 3;
  localparam int HOLD_W = 4;
endpackage

// File: rtl/tdm_mux_if.sv
// rtl/tdm_mux_if.sv - TDM multiplexer request/serial bus interface
// Purpose: bundles the frame request handshake and the serialized slot bus.
// Ports:   start/din (request side), ack/ovr (handshake status),
//          mout/sel/mvalid/frame_end (serial slot bus).
//          master = requester/receiver side, slave = multiplexer side.
interface tdm_mux_if;
  import tdm_pkg::*;

  logic             start;
  logic [SLOTS-1:0] din;
  logic             ack;
  logic             ovr;
  logic             mout;
  logic [SEL_W-1:0] sel;
  logic             mvalid;
  logic             frame_end;

  modport master (
    output start, din,
    input  ack, ovr, mout, sel, mvalid, frame_end
  );

  modport slave (
    input  start, din,
    output ack, ovr, mout, sel, mvalid, frame_end
  );
endinterface

// File: rtl/tdm_mux_slot_timer.sv
// rtl/tdm_mux_slot_timer.sv - per-slot hold counter
// Purpose: counts 0..HOLD-1 while run is high and flags the last cycle of
//          each slot; held at 0 while run is low.
// Ports:   clk, rst_n (async active-low), run (count enable),
//          cnt (current hold count), slot_done (last cycle of the slot).
module slot_timer
  import tdm_pkg::*;
#(
  parameter int HOLD = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic [HOLD_W-1:0] cnt,
  output logic              slot_done
);
  localparam logic [HOLD_W-1:0] LAST = HOLD_W'(HOLD - 1);

  logic [HOLD_W-1:0] cnt_q;
  logic [HOLD_W-1:0] cnt_d;

  assign slot_done = run && (cnt_q == LAST);
  assign cnt       = cnt_q;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!run || slot_done) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/tdm_mux.sv
// rtl/tdm_mux.sv - 8-slot time-division multiplexer
// Purpose: captures an 8-bit frame on start and serializes it one slot per
//          HOLD cycles on mout/sel, with back-to-back frame support.
// Ports:   clk, rst_n (async active-low), bus (tdm_mux_if.slave):
//          start/din in, ack/ovr/mout/sel/mvalid/frame_end out (all registered).
module tdm_mux
  import tdm_pkg::*;
#(
  parameter int HOLD = 1
) (
  input  logic      clk,
  input  logic      rst_n,
  tdm_mux_if.slave  bus
);
  localparam logic [SEL_W-1:0]  LAST_SLOT = SEL_W'(SLOTS - 1);
  localparam logic [SEL_W-1:0]  PREV_SLOT = SEL_W'(SLOTS - 2);
  localparam logic [HOLD_W-1:0] PRE_LAST  = HOLD_W'(HOLD - 2);

  tdm_state_e       state_q;
  logic [SLOTS-1:0] shadow_q;
  logic [SEL_W-1:0] sel_q;
  logic             mout_q;
  logic             mvalid_q;
  logic             ack_q;
  logic             ovr_q;
  logic             frame_end_q;

  logic [HOLD_W-1:0] cnt;
  logic              slot_done;
  logic              run;
  logic              frame_last;
  logic              pre_last;
  logic [SEL_W-1:0]  next_sel;

  assign run        = (state_q == SEND);
  assign frame_last = (sel_q == LAST_SLOT) && slot_done;
  // Next cycle is the final hold cycle of the current slot (only exists when HOLD > 1).
  assign pre_last   = (HOLD > 1) && (cnt == PRE_LAST);
  assign next_sel   = sel_q + 1'b1;

  slot_timer #(.HOLD(HOLD)) u_slot_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .cnt       (cnt),
    .slot_done (slot_done)
  );

  // Acceptance from IDLE spends one cycle in IDLE with ack high; slot 0 follows.
  // Back-to-back acceptance in the frame_end cycle goes straight to slot 0.
  // frame_end is registered one cycle ahead so it lands on the last slot-7 cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shadow_q    <= '0;
      sel_q       <= '0;
      mout_q      <= 1'b0;
      mvalid_q    <= 1'b0;
      ack_q       <= 1'b0;
      ovr_q       <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      ack_q       <= 1'b0;
      ovr_q       <= 1'b0;
      frame_end_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ack_q) begin
            state_q  <= SEND;
            sel_q    <= '0;
            mout_q   <= shadow_q[0];
            mvalid_q <= 1'b1;
            ovr_q    <= bus.start;
          end else if (bus.start) begin
            shadow_q <= bus.din;
            ack_q    <= 1'b1;
          end
        end
        SEND: begin
          if (frame_last) begin
            sel_q <= '0;
            if (bus.start) begin
              shadow_q <= bus.din;
              ack_q    <= 1'b1;
              mout_q   <= bus.din[0];
            end else begin
              state_q  <= IDLE;
              mout_q   <= 1'b0;
              mvalid_q <= 1'b0;
            end
          end else begin
            ovr_q <= bus.start;
            if (slot_done) begin
              sel_q       <= next_sel;
              mout_q      <= shadow_q[next_sel];
              frame_end_q <= (HOLD == 1) && (sel_q == PREV_SLOT);
            end else begin
              frame_end_q <= pre_last && (sel_q == LAST_SLOT);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ack       = ack_q;
  assign bus.ovr       = ovr_q;
  assign bus.mout      = mout_q;
  assign bus.sel       = sel_q;
  assign bus.mvalid    = mvalid_q;
  assign bus.frame_end = frame_end_q;
endmodule
